// File: rtl/nbits_pipelined_adder.sv
// nbits_pipelined_adder
// WIDTH-bit add/subtract with the carry chain split into STAGES equal slices,
// one slice resolved per register stage. Upper operand slices travel forward
// with each beat until their stage. Lower result slices are carried along so
// the whole sum appears together at the output.
//
// Handshake (valid/ready): a beat moves across an interface on a rising edge
// where valid && ready are both high. in_valid/out_valid must not depend on
// the ready they are paired with. The whole pipeline advances as one unit:
// adv = !out_valid || out_ready. When adv=0, every stage register holds,
// including the valid bits, so the presented result is stable. in_ready is adv.
module nbits_pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int SW  = (STAGES >= 1) ? (WIDTH / STAGES) : 1;
  localparam int REM = (STAGES >= 1) ? (WIDTH % STAGES) : 1;

  if (WIDTH < 1 || STAGES < 1 || REM != 0) begin : g_bad_params
    $error("nbits_pipelined_adder: WIDTH must be >= 1 and STAGES >= 1 must divide WIDTH");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  // Subtraction is a + ~b + ~cin, so that a borrow-in of 1 subtracts one more.
  assign b_eff    = sub ? ~b : b;
  assign c_eff    = sub ? ~cin : cin;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // LO: lowest bit index this stage resolves.
    // PW: operand bits still pending when a beat enters this stage.
    localparam int LO = k * SW;
    localparam int PW = WIDTH - LO;

    logic             v_in;
    logic             c_in;
    logic [PW-1:0]    a_in;
    logic [PW-1:0]    b_in;
    logic [SW:0]      sum;
    logic [LO+SW-1:0] s_next;

    logic             v_r;
    logic             c_r;
    logic [LO+SW-1:0] s_r;

    if (k == 0) begin : g_src
      assign v_in   = in_valid;
      assign c_in   = c_eff;
      assign a_in   = a;
      assign b_in   = b_eff;
      assign s_next = sum[SW-1:0];
    end else begin : g_src
      assign v_in   = g_stage[k-1].v_r;
      assign c_in   = g_stage[k-1].c_r;
      assign a_in   = g_stage[k-1].g_fwd.a_r;
      assign b_in   = g_stage[k-1].g_fwd.b_r;
      assign s_next = {sum[SW-1:0], g_stage[k-1].s_r};
    end

    // The slice adder: the low SW pending bits plus the carry from below.
    assign sum = {1'b0, a_in[SW-1:0]} + {1'b0, b_in[SW-1:0]} + {{SW{1'b0}}, c_in};

    // Valid bit, slice carry and accumulated low result for this stage.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_r <= 1'b0;
        c_r <= 1'b0;
        s_r <= '0;
      end else if (adv) begin
        v_r <= v_in;
        c_r <= sum[SW];
        s_r <= s_next;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      // Operand slices not yet added. They shrink by one slice per stage.
      logic [PW-SW-1:0] a_r;
      logic [PW-SW-1:0] b_r;

      // Skew register: carry the unresolved upper operand slices forward.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_r <= '0;
          b_r <= '0;
        end else if (adv) begin
          a_r <= a_in[PW-1:SW];
          b_r <= b_in[PW-1:SW];
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic ovf_r;
      logic ovf_next;

      // The carry into the MSB is a^b^s at the MSB. Overflow is that carry
      // XOR the carry out of the MSB.
      assign ovf_next = a_in[PW-1] ^ b_in[PW-1] ^ sum[SW-1] ^ sum[SW];

      // Overflow flag, captured alongside the final slice.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_r <= 1'b0;
        end else if (adv) begin
          ovf_r <= ovf_next;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_r;
  assign s         = g_stage[STAGES-1].s_r;
  assign cout      = g_stage[STAGES-1].c_r;
  assign ovf       = g_stage[STAGES-1].g_last.ovf_r;

endmodule

// File: tb/tb_nbits_pipelined_adder.sv
// Bench for nbits_pipelined_adder: three instances (16/4, 8/1, 32/8), each
// with its own reset, directed vectors, random stream and mid-stream reset.
// The reference model computes results with plain signed/unsigned arithmetic.
module tb_nbits_pipelined_adder;

  logic clk;
  int   n_cmp;
  int   n_fail;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
    localparam int W = (gi == 0) ? 16 : (gi == 1) ? 8 : 32;
    localparam int S = (gi == 0) ? 4 : (gi == 1) ? 1 : 8;

    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    logic         done;

    logic [W+1:0] exp_q[$];
    logic         stall_prev;
    logic [W+2:0] prev_out;

    nbits_pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .cout      (cout),
      .ovf       (ovf)
    );

    function automatic string nm(input string x);
      return $sformatf("W%0d_S%0d %s", W, S, x);
    endfunction

    function automatic longint sx(input logic [W-1:0] x);
      return x[W-1] ? (longint'(x) - (longint'(1) << W)) : longint'(x);
    endfunction

    // Reference model: returns {ovf, cout, s}.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci, input logic sb);
      longint ur;
      longint sr;
      longint smax;
      longint smin;
      logic   co;
      logic   ov;
      logic [W-1:0] r;
      smax = (longint'(1) << (W - 1)) - 1;
      smin = -(longint'(1) << (W - 1));
      if (sb) begin
        ur = longint'(x) - longint'(y) - longint'(ci);
        sr = sx(x) - sx(y) - longint'(ci);
        co = (ur >= 0);
      end else begin
        ur = longint'(x) + longint'(y) + longint'(ci);
        sr = sx(x) + sx(y) + longint'(ci);
        co = (ur >= (longint'(1) << W));
      end
      ov = (sr > smax) || (sr < smin);
      r  = ur[W-1:0];
      return {ov, co, r};
    endfunction

    // Compare process: handshake rule, stall stability, in-order results.
    always @(negedge clk) begin
      if (rst_n) begin
        check(nm("in_ready"), in_ready, !out_valid || out_ready);
        if (stall_prev) check(nm("stall_hold"), {out_valid, ovf, cout, s}, prev_out);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: got result %0h expected no result", nm("unexpected_out"), {ovf, cout, s});
          end else begin
            check(nm("result"), {ovf, cout, s}, exp_q.pop_front());
          end
        end
        if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
        stall_prev = out_valid && !out_ready;
        prev_out   = {out_valid, ovf, cout, s};
      end
    end

    task automatic drive_one(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                             input logic tc, input logic ts,
                             input logic [W+1:0] exp, input string tag);
      int cnt;
      check(nm({tag, "_model"}), model(ta, tb_v, tc, ts), exp);
      a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      cnt = 0;
      while (!out_valid && cnt < 4 * S + 10) begin
        @(posedge clk); #1;
        cnt++;
      end
      check(nm({tag, "_latency"}), cnt, S - 1);
      check(nm({tag, "_out"}), {ovf, cout, s}, exp);
      @(posedge clk); #1;
    endtask

    initial begin
      logic [W-1:0] ones, zero, mn, mx, m2, five, seven, one;
      int acc, guard, cnt, seen;
      done = 1'b0; stall_prev = 1'b0; prev_out = '0;
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
      ones = '1; zero = '0; mn = '0; mn[W-1] = 1'b1; mx = ~mn;
      m2 = ones; m2[0] = 1'b0; five = W'(5); seven = W'(7); one = W'(1);

      repeat (3) @(posedge clk);
      #1;
      check(nm("rst_out_valid"), out_valid, 0);
      check(nm("rst_s"), s, 0);
      check(nm("rst_cout"), cout, 0);
      check(nm("rst_ovf"), ovf, 0);
      check(nm("rst_in_ready"), in_ready, 1);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(posedge clk); #1;
        check(nm("idle_out_valid"), out_valid, 0);
        check(nm("idle_in_ready"), in_ready, 1);
      end

      out_ready = 1'b1;
      drive_one(ones, zero, 1'b1, 1'b0, {1'b0, 1'b1, zero}, "ripple");
      drive_one(five, seven, 1'b0, 1'b1, {1'b0, 1'b0, m2}, "sub_borrow");
      drive_one(mn, one, 1'b0, 1'b1, {1'b1, 1'b1, mx}, "sub_ovf");
      drive_one(mx, one, 1'b0, 1'b0, {1'b1, 1'b0, mn}, "add_ovf");
      drive_one(zero, zero, 1'b1, 1'b1, {1'b0, 1'b0, ones}, "sub_bin");
      drive_one(ones, ones, 1'b1, 1'b0, {1'b0, 1'b1, ones}, "add_neg");

      acc = 0; guard = 0;
      while (acc < 200 && guard < 5000) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        a         = W'($urandom());
        b         = W'($urandom());
        cin       = 1'($urandom_range(0, 1));
        sub       = 1'($urandom_range(0, 1));
        out_ready = ($urandom_range(0, 2) != 0);
        @(negedge clk);
        if (in_valid && in_ready) acc++;
        @(posedge clk); #1;
        guard++;
      end
      check(nm("stream_accepted"), acc, 200);
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (S + 3) @(posedge clk);
      #1;
      check(nm("drain_empty"), exp_q.size(), 0);

      for (int j = 0; j < 3; j++) begin
        in_valid = 1'b1; a = W'($urandom()); b = W'($urandom());
        cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      cnt = 0;
      while (!out_valid && cnt < 4 * S + 10) begin
        @(posedge clk); #1;
        cnt++;
      end
      check(nm("pre_reset_valid"), out_valid, 1);
      #1 rst_n = 1'b0;
      #1;
      check(nm("async_out_valid"), out_valid, 0);
      check(nm("async_s"), s, 0);
      check(nm("async_cout"), cout, 0);
      check(nm("async_ovf"), ovf, 0);
      check(nm("async_in_ready"), in_ready, 1);
      exp_q.delete();
      stall_prev = 1'b0;
      #1 rst_n = 1'b1;
      out_ready = 1'b1; seen = 0;
      repeat (2 * S + 6) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      check(nm("no_stale"), seen, 0);
      done = 1'b1;
    end
  end

  initial begin
    n_cmp = 0;
    n_fail = 0;
    wait (g_cfg[0].done && g_cfg[1].done && g_cfg[2].done);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_cmp++;
    n_fail++;
    $display("FAIL watchdog: got timeout expected all instances done");
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
